mem_arbiter: RTL and testbench

Sequencer and arbiter for the single byte-wide unified RAM port shared by instruction fetch and the load/store stage. It grants one requester at a time, issues byte-serial RAM accesses, assembles or splits 32-bit data little-endian, and returns a one-cycle done pulse. Requesters hold their stall request from request until done. A taken jump from EX aborts an in-flight fetch.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbiter/sequencer for the shared byte-wide RAM port (fetch vs load/store)

module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_inst,
   output logic              if_done,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_len,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   input  logic              jump,
   input  logic [7:0]        ram_din,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr,
   output logic [7:0]        ram_dout
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state, state_n;
   logic              owner_mem, owner_mem_n;
   logic [2:0]        cnt, cnt_n, nbytes, nbytes_n;
   logic [ADDR_W-1:0] base, base_n, ram_a_n;
   logic [31:0]       wdata, wdata_n, acc, acc_n, if_inst_n, mem_rdata_n;
   logic              ram_wr_n;
   logic [7:0]        ram_dout_n;
   logic [2:0]        cnt_inc, cnt_dec;
   logic [ADDR_W-1:0] next_addr;

   assign cnt_inc   = cnt + 3'd1;
   assign cnt_dec   = cnt - 3'd1;
   assign next_addr = base + ADDR_W'(cnt_inc);

   assign if_done  = (state == DONE) && !owner_mem;
   assign mem_done = (state == DONE) && owner_mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner_mem <= 1'b0;
         cnt       <= 3'd0;
         nbytes    <= 3'd0;
         base      <= '0;
         wdata     <= '0;
         acc       <= '0;
         if_inst   <= '0;
         mem_rdata <= '0;
         ram_a     <= '0;
         ram_wr    <= 1'b0;
         ram_dout  <= 8'd0;
      end else begin
         state     <= state_n;
         owner_mem <= owner_mem_n;
         cnt       <= cnt_n;
         nbytes    <= nbytes_n;
         base      <= base_n;
         wdata     <= wdata_n;
         acc       <= acc_n;
         if_inst   <= if_inst_n;
         mem_rdata <= mem_rdata_n;
         ram_a     <= ram_a_n;
         ram_wr    <= ram_wr_n;
         ram_dout  <= ram_dout_n;
      end
   end

   always_comb begin
      state_n     = state;
      owner_mem_n = owner_mem;
      cnt_n       = cnt;
      nbytes_n    = nbytes;
      base_n      = base;
      wdata_n     = wdata;
      acc_n       = acc;
      if_inst_n   = if_inst;
      mem_rdata_n = mem_rdata;
      ram_a_n     = '0;
      ram_wr_n    = 1'b0;
      ram_dout_n  = 8'd0;

      unique case (state)
         IDLE: begin
            // MEM wins: it belongs to the older instruction in the pipe
            if (mem_req) begin
               owner_mem_n = 1'b1;
               base_n      = mem_addr;
               wdata_n     = mem_wdata;
               nbytes_n    = (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;
               cnt_n       = 3'd0;
               acc_n       = '0;
               ram_a_n     = mem_addr;
               if (mem_we) begin
                  state_n    = WRITE;
                  ram_wr_n   = 1'b1;
                  ram_dout_n = mem_wdata[7:0];
               end else begin
                  state_n = READ;
               end
            end else if (if_req && !jump) begin
               owner_mem_n = 1'b0;
               base_n      = if_addr;
               nbytes_n    = 3'd4;
               cnt_n       = 3'd0;
               acc_n       = '0;
               ram_a_n     = if_addr;
               state_n     = READ;
            end
         end
         READ: begin
            if (!owner_mem && jump) begin
               state_n = IDLE;
               cnt_n   = 3'd0;
            end else begin
               // ram_din lags the address by one cycle, so byte cnt-1 arrives now
               if (cnt != 3'd0)
                  acc_n[{cnt_dec[1:0], 3'b000} +: 8] = ram_din;
               if (cnt_inc < nbytes)
                  ram_a_n = next_addr;
               if (cnt == nbytes) begin
                  state_n = DONE;
                  cnt_n   = 3'd0;
                  if (owner_mem)
                     mem_rdata_n = acc_n;
                  else
                     if_inst_n = acc_n;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         WRITE: begin
            if (cnt_inc < nbytes) begin
               ram_a_n    = next_addr;
               ram_wr_n   = 1'b1;
               ram_dout_n = wdata[{cnt_inc[1:0], 3'b000} +: 8];
               cnt_n      = cnt_inc;
            end else begin
               state_n = DONE;
               cnt_n   = 3'd0;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with byte RAM model and shadow reference

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we, jump;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [1:0]  mem_len;
   logic [31:0] if_inst, mem_rdata, ram_a;
   logic        if_done, mem_done, ram_wr;
   logic [7:0]  ram_din, ram_dout;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .jump(jump), .ram_din(ram_din), .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h1000: return 8'h13;
         32'h1001: return 8'h05;
         32'h1002: return 8'h10;
         32'h1003: return 8'h00;
         32'h0020: return 8'hF5;
         32'h0032: return 8'h11;
         32'h0033: return 8'h22;
         32'h2000: return 8'hB7;
         32'h2001: return 8'h02;
         32'h2002: return 8'h00;
         32'h2003: return 8'h40;
         default:  return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   logic [7:0] ram    [logic [31:0]];
   logic [7:0] shadow [logic [31:0]];

   always @(posedge clk) begin
      ram_din <= ram.exists(ram_a) ? ram[ram_a] : init_byte(ram_a);
      if (ram_wr) ram[ram_a] = ram_dout;
   end

   function automatic logic [7:0] shadow_rd(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : init_byte(a);
   endfunction

   function automatic int len_bytes(input logic [1:0] len);
      return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Caller is at a negedge with the arbiter idle; returns the data seen in the done cycle.
   task automatic do_txn(input bit fetch, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output int lat);
      int n;
      bit st;
      n  = fetch ? 4 : len_bytes(len);
      st = !fetch && we;
      if (fetch) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat <= n)
            chk("ram_port", {ram_a, 7'd0, ram_wr, 16'd0, ram_dout},
                {addr + 32'(lat - 1), 7'd0, st, 16'd0, st ? 8'(wdata >> (8 * (lat - 1))) : 8'h00});
         else
            chk("ram_wr_idle", {63'd0, ram_wr}, 64'd0);
      end while (!(fetch ? if_done : mem_done) && lat < 40);
      data = fetch ? if_inst : mem_rdata;
      if_req = 1'b0; mem_req = 1'b0;
      if (st)
         for (int k = 0; k < n; k++) shadow[addr + 32'(k)] = 8'(wdata >> (8 * k));
   endtask

   typedef struct {
      bit          fetch;
      bit          we;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [31:0] d, exp, prev;
      int lat, cyc, n;
      bit fetch, we;
      logic [1:0] len;
      logic [31:0] addr, wdata;

      vecs[0] = '{1, 0, 2'b10, 32'h0000_1000, 32'h0, 32'h0010_0513, 6};
      vecs[1] = '{0, 0, 2'b00, 32'h0000_0020, 32'h0, 32'h0000_00F5, 3};
      vecs[2] = '{0, 1, 2'b01, 32'h0000_0030, 32'hAABB_CCDD, 32'h0, 3};
      vecs[3] = '{0, 0, 2'b10, 32'h0000_0030, 32'h0, 32'h2211_CCDD, 6};
      vecs[4] = '{0, 0, 2'b01, 32'h0000_1001, 32'h0, 32'h0000_1005, 4};
      vecs[5] = '{0, 0, 2'b11, 32'h0000_1000, 32'h0, 32'h0010_0513, 6};
      vecs[6] = '{0, 1, 2'b10, 32'hFFFF_FFFE, 32'h4433_2211, 32'h0, 5};
      vecs[7] = '{0, 0, 2'b10, 32'hFFFF_FFFE, 32'h0, 32'h4433_2211, 6};
      vecs[8] = '{0, 1, 2'b00, 32'h0000_0040, 32'h0000_00A5, 32'h0, 2};
      vecs[9] = '{0, 0, 2'b10, 32'h0000_0040, 32'h0, 32'h1918_1BA5, 6};

      rst = 1'b1; if_req = 1'b1; if_addr = 32'h1000; mem_req = 1'b0; mem_we = 1'b0;
      mem_len = 2'b00; mem_addr = '0; mem_wdata = '0; jump = 1'b0;

      // Reset with a pending fetch: everything stays quiet
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("reset_outputs", {if_done, mem_done, ram_wr, 1'b0, ram_dout, 24'd0},
             64'd0);
         chk("reset_data", {if_inst, mem_rdata}, 64'd0);
         chk("reset_ram_a", {32'd0, ram_a}, 64'd0);
      end
      rst = 1'b0;
      do_txn(1, 0, 2'b10, 32'h1000, 32'h0, d, lat);
      chk("reset_fetch_data", {32'd0, d}, {32'd0, 32'h0010_0513});
      chk("reset_fetch_lat", 64'(lat), 64'd6);

      foreach (vecs[i]) begin
         @(negedge clk);
         do_txn(vecs[i].fetch, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, d, lat);
         if (!vecs[i].we) chk($sformatf("vec%0d_data", i), {32'd0, d}, {32'd0, vecs[i].exp_data});
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      end

      // Contention: MEM byte load wins, IF granted the cycle after DONE
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h1000;
      mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h20;
      cyc = 0;
      do begin @(negedge clk); cyc++; chk("contend_no_if_done", {63'd0, if_done}, 64'd0); end
      while (!mem_done && cyc < 40);
      chk("contend_mem_lat", 64'(cyc), 64'd3);
      chk("contend_mem_data", {32'd0, mem_rdata}, 64'h0000_00F5);
      mem_req = 1'b0;
      do begin @(negedge clk); cyc++; end while (!if_done && cyc < 40);
      chk("contend_if_lat", 64'(cyc), 64'd10);
      chk("contend_if_data", {32'd0, if_inst}, 64'h0010_0513);
      if_req = 1'b0;

      // Jump abort at t+3 of a fetch, then immediate refetch
      @(negedge clk);
      prev = if_inst;
      if_req = 1'b1; if_addr = 32'h1000;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("abort_no_done", {63'd0, if_done}, 64'd0);
         if (c == 3) jump = 1'b1;
      end
      @(negedge clk);
      jump = 1'b0; if_addr = 32'h2000;
      chk("abort_state", {31'd0, if_done, ram_a}, 64'd0);
      chk("abort_inst_held", {32'd0, if_inst}, {32'd0, prev});
      @(negedge clk);
      chk("refetch_first_addr", {32'd0, ram_a}, 64'h2000);
      cyc = 1;
      while (!if_done && cyc < 40) begin @(negedge clk); cyc++; end
      chk("refetch_lat", 64'(cyc), 64'd6);
      chk("refetch_data", {32'd0, if_inst}, 64'h4000_02B7);
      if_req = 1'b0;

      // Randomized traffic against the shadow memory
      for (int i = 0; i < 40; i++) begin
         fetch = ($urandom_range(0, 2) == 0);
         we    = !fetch && $urandom_range(0, 1);
         len   = 2'($urandom_range(0, 3));
         addr  = $urandom_range(0, 1) ? 32'h100 + 32'($urandom_range(0, 15))
                                      : 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         wdata = $urandom;
         n     = fetch ? 4 : len_bytes(len);
         exp   = '0;
         for (int k = 0; k < n; k++) exp |= 32'(shadow_rd(addr + 32'(k))) << (8 * k);
         @(negedge clk);
         do_txn(fetch, we, len, addr, wdata, d, lat);
         if (!we) chk("rand_data", {32'd0, d}, {32'd0, exp});
         chk("rand_lat", 64'(lat), 64'(we ? n + 1 : n + 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
